div_result_collector: RTL

- Sits directly downstream of the restoring divider datapath/CU pair.
- Captures the remainder (A) and quotient (Q), which are driven serially on the divider's shared output bus during the OUTPUT_A and OUTPUT_Q control steps.
- Pairs the two words on the divider's stop pulse and buffers them in a small FIFO.
- Presents results to the consumer over a valid/ready handshake, and flags protocol errors and overflow.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_result_fifo.sv | 39 +++
 rtl/div_result_collector.sv | 84 ++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and control-bit indices for the divider result collector
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int C_OUT_A = 7;
  localparam int C_OUT_Q = 8;
  typedef enum logic [1:0] {WAIT_A, WAIT_Q, WAIT_STOP} cap_state_t;
  typedef struct packed {
    logic [DIV_WIDTH-1:0] remainder;
    logic [DIV_WIDTH-1:0] quotient;
  } div_result_t;
endpackage

// File: rtl/div_result_fifo.sv
// div_result_fifo: synchronous result FIFO; head holds the last popped entry while empty
module div_result_fifo import div_pkg::*; #(
  parameter type T = div_result_t,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  T last_r;
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? last_r : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        last_r <= mem[rd_ptr[AW-1:0]];
      end
    end
endmodule

// File: rtl/div_result_collector.sv
// div_result_collector: pairs serial remainder/quotient words from the divider and queues them for a consumer
module div_result_collector import div_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] outbus,
  input  logic             out_a,
  input  logic             out_q,
  input  logic             stop,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             full,
  output logic             overflow,
  output logic             proto_err,
  input  logic             clr_flags
);
  typedef struct packed {
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] quotient;
  } res_t;
  cap_state_t state;
  logic [WIDTH-1:0] rem_r, quo_r;
  logic both, pop, push_req, empty;
  res_t head;
  assign both = out_a && out_q;
  assign pop = res_valid && res_ready;
  assign push_req = state == WAIT_STOP && stop && !both;
  assign res_valid = !empty;
  assign remainder = head.remainder;
  assign quotient = head.quotient;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= WAIT_A;
      rem_r <= '0;
      quo_r <= '0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      overflow <= (push_req && full && !pop) || (overflow && !clr_flags);
      if (both) proto_err <= 1'b1;
      else
        case (state)
          WAIT_A:
            if (out_a) begin
              rem_r <= outbus;
              state <= WAIT_Q;
            end else if (out_q || stop) proto_err <= 1'b1;
          WAIT_Q:
            if (out_q) begin
              quo_r <= outbus;
              state <= WAIT_STOP;
            end else if (out_a) begin
              proto_err <= 1'b1;
              rem_r <= outbus;
            end else if (stop) begin
              proto_err <= 1'b1;
              state <= WAIT_A;
            end
          WAIT_STOP:
            if (stop) state <= WAIT_A;
            else if (out_a) begin
              proto_err <= 1'b1;
              rem_r <= outbus;
              state <= WAIT_Q;
            end else if (out_q) proto_err <= 1'b1;
          default: state <= WAIT_A;
        endcase
    end
  div_result_fifo #(.T(res_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push_req),
    .pop(pop),
    .din('{remainder: rem_r, quotient: quo_r}),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
